// File: rtl/eq_pkg.sv
// Shared constants for the I2S transmitter.
// SMPL_W          : audio sample width
// CNT_W           : free-running frame counter width (2048 clk per frame)
// SLOTS           : SCLK periods per LRCLK half
// MCLK/SCLK/LRCLK : counter bit indices that drive each output clock
package eq_pkg;
  localparam int SMPL_W    = 24;
  localparam int CNT_W     = 11;
  localparam int SLOTS     = 32;
  localparam int SLOT_W    = $clog2(SLOTS);
  localparam int MCLK_BIT  = 1;
  localparam int SCLK_BIT  = 4;
  localparam int LRCLK_BIT = 10;

  typedef logic [SMPL_W-1:0] smpl_t;
  typedef logic [SLOT_W-1:0] slot_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter and the codec clocks derived from it.
// Ports:
//   clk, RST_n      : system clock, async active-low reset
//   mclk_o          : clk/4, bit MCLK_BIT of the counter
//   sclk_o          : clk/32, bit SCLK_BIT of the counter
//   lrclk_o         : clk/2048, bit LRCLK_BIT of the counter (low = left)
//   sclk_fall_o     : high on the cycle whose closing edge makes SCLK fall
//   frame_start_o   : high on the cycle whose closing edge wraps 2047->0
//   nxt_slot_o      : slot index that becomes current after this edge
//   nxt_lr_o        : LRCLK value that becomes current after this edge
module i2s_clk_gen
  import eq_pkg::*;
(
  input  logic  clk,
  input  logic  RST_n,
  output logic  mclk_o,
  output logic  sclk_o,
  output logic  lrclk_o,
  output logic  sclk_fall_o,
  output logic  frame_start_o,
  output slot_t nxt_slot_o,
  output logic  nxt_lr_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Clocks are taken straight from counter flops so they are glitch-free.
  assign mclk_o  = cnt_q[MCLK_BIT];
  assign sclk_o  = cnt_q[SCLK_BIT];
  assign lrclk_o = cnt_q[LRCLK_BIT];

  assign sclk_fall_o   = (cnt_q[SCLK_BIT:0] == '1);
  assign frame_start_o = (cnt_q == '1);

  // Look-ahead slot/channel so data registered at SCLK fall lands in its slot.
  assign nxt_slot_o = cnt_d[LRCLK_BIT-1:SCLK_BIT+1];
  assign nxt_lr_o   = cnt_d[LRCLK_BIT];

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: double-buffered stereo 24-bit samples sent MSB first
// with the standard one-bit delay after each LRCLK transition.
// Ports:
//   clk, RST_n      : 50 MHz system clock, async active-low reset
//   lft_in, rht_in  : signed left/right samples
//   wrt             : one-clk strobe loading both holding registers
//   frm_req         : one-clk pulse when holding data moves into the shifters
//   MCLK/SCLK/LRCLK : codec clocks (clk/4, clk/32, clk/2048)
//   SDin            : serial data, changes only on SCLK falling edges
module i2s_tx
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              RST_n,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rht_in,
  input  logic              wrt,
  output logic              frm_req,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin
);

  logic  sclk_fall, frame_start, nxt_lr;
  slot_t nxt_slot;

  smpl_t lft_hld_q, rht_hld_q;
  smpl_t lft_shft_q, rht_shft_q;
  logic  sdin_q, frm_req_q;
  logic  data_slot;

  i2s_clk_gen u_clk_gen (
    .clk           (clk),
    .RST_n         (RST_n),
    .mclk_o        (MCLK),
    .sclk_o        (SCLK),
    .lrclk_o       (LRCLK),
    .sclk_fall_o   (sclk_fall),
    .frame_start_o (frame_start),
    .nxt_slot_o    (nxt_slot),
    .nxt_lr_o      (nxt_lr)
  );

  // Slot 0 carries the I2S one-bit delay; slots past the word are padded.
  assign data_slot = (nxt_slot >= slot_t'(1)) && (nxt_slot <= slot_t'(SMPL_W));

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      lft_hld_q  <= '0;
      rht_hld_q  <= '0;
      lft_shft_q <= '0;
      rht_shft_q <= '0;
      sdin_q     <= 1'b0;
      frm_req_q  <= 1'b0;
    end else begin
      frm_req_q <= frame_start;
      if (wrt) begin
        lft_hld_q <= lft_in;
        rht_hld_q <= rht_in;
      end
      if (sclk_fall) begin
        if (frame_start) begin
          // A write on this same edge lands in the holding regs only,
          // so the shifters get the previous pair.
          lft_shft_q <= lft_hld_q;
          rht_shft_q <= rht_hld_q;
          sdin_q     <= 1'b0;
        end else if (data_slot) begin
          if (nxt_lr) begin
            sdin_q     <= rht_shft_q[SMPL_W-1];
            rht_shft_q <= {rht_shft_q[SMPL_W-2:0], 1'b0};
          end else begin
            sdin_q     <= lft_shft_q[SMPL_W-1];
            lft_shft_q <= {lft_shft_q[SMPL_W-2:0], 1'b0};
          end
        end else begin
          sdin_q <= 1'b0;
        end
      end
    end
  end

  assign SDin    = sdin_q;
  assign frm_req = frm_req_q;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] lft_in, rht_in;
  logic        wrt;
  logic        frm_req, MCLK, SCLK, LRCLK, SDin;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference frame counter, advanced by the bench from the same clock/reset.
  logic [10:0] tcnt;

  always #10 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 11'd0;
    else        tcnt <= tcnt + 11'd1;
  end

  i2s_tx dut (
    .clk     (clk),
    .RST_n   (rst_n),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .wrt     (wrt),
    .frm_req (frm_req),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [10:0] t);
    for (int i = 0; i < 4200 && tcnt != t; i++) @(negedge clk);
    if (tcnt != t) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_cnt: timeout waiting for cnt %0d", t);
    end
  endtask

  task automatic write_at(input logic [10:0] t, input logic [23:0] l, input logic [23:0] r);
    wait_cnt(t);
    lft_in = l;
    rht_in = r;
    wrt    = 1'b1;
    @(negedge clk);
    wrt    = 1'b0;
  endtask

  // Captures one full frame starting at cnt==0, sampling SDin mid-slot
  // (SCLK high), and tallies clock/strobe irregularities.
  task automatic capture_frame(input logic do_wr, input logic [23:0] wl, input logic [23:0] wr,
                               output logic [23:0] gl, output logic [23:0] gr,
                               output int bad_fill, output int bad_clk, output int nreq);
    logic prev;
    int   b;
    wait_cnt(11'd0);
    gl = '0; gr = '0; bad_fill = 0; bad_clk = 0; nreq = 0;
    prev = SDin;
    for (int i = 0; i < 2048; i++) begin
      if (do_wr && i == 0) begin
        lft_in = wl;
        rht_in = wr;
        wrt    = 1'b1;
      end else begin
        wrt = 1'b0;
      end
      if (MCLK !== tcnt[1] || SCLK !== tcnt[4] || LRCLK !== tcnt[10]) bad_clk++;
      if (SDin !== prev && tcnt[4:0] != 5'd0) bad_clk++;
      prev = SDin;
      if (frm_req === 1'b1) begin
        nreq++;
        if (tcnt != 11'd0) bad_clk++;
      end
      if (tcnt[4:0] == 5'd16) begin
        b = int'(tcnt[9:5]);
        if (b >= 1 && b <= 24) begin
          if (tcnt[10]) gr[24-b] = SDin;
          else          gl[24-b] = SDin;
        end else if (SDin !== 1'b0) begin
          bad_fill++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic frame_check(input string nm, input logic do_wr, input logic [23:0] wl,
                             input logic [23:0] wr, input logic [23:0] el, input logic [23:0] er,
                             input int ereq);
    logic [23:0] gl, gr;
    int bf, bc, nr;
    capture_frame(do_wr, wl, wr, gl, gr, bf, bc, nr);
    chk({nm, " left"},  {8'h0, gl}, {8'h0, el});
    chk({nm, " right"}, {8'h0, gr}, {8'h0, er});
    chk({nm, " pad"},   bf, 0);
    chk({nm, " clk"},   bc, 0);
    chk({nm, " frm_req"}, nr, ereq);
  endtask

  vec_t tv[4];
  logic [23:0] sine[4];
  int n;

  initial begin
    tv[0] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
    tv[1] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
    tv[2] = '{24'h000001, 24'hFFFFFE, 24'h000001, 24'hFFFFFE};
    tv[3] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    sine[0] = 24'h000000;
    sine[1] = 24'h104000;
    sine[2] = 24'h1F7000;
    sine[3] = 24'h2D4000;

    rst_n = 1'b0; wrt = 1'b0; lft_in = '0; rht_in = '0;
    repeat (5) @(negedge clk);
    chk("rst MCLK", MCLK, 0);
    chk("rst SCLK", SCLK, 0);
    chk("rst LRCLK", LRCLK, 0);
    chk("rst SDin", SDin, 0);
    chk("rst frm_req", frm_req, 0);
    rst_n = 1'b1;

    // First frame after reset: counter starts at 0, no frame edge yet.
    frame_check("first", 1'b0, '0, '0, 24'h0, 24'h0, 0);

    for (int k = 0; k < 4; k++) begin
      write_at(11'd1000, tv[k].l, tv[k].r);
      frame_check($sformatf("vec%0d", k), 1'b0, '0, '0, tv[k].el, tv[k].er, 1);
    end

    // Several writes in one frame: last one wins.
    write_at(11'd500, 24'h111111, 24'h222222);
    write_at(11'd1500, 24'h333333, 24'h444444);
    frame_check("lastwin", 1'b0, '0, '0, 24'h333333, 24'h444444, 1);

    // No writes: same pair repeats every frame.
    write_at(11'd1000, 24'h800000, 24'h0F0F0F);
    for (int k = 0; k < 3; k++)
      frame_check($sformatf("repeat%0d", k), 1'b0, '0, '0, 24'h800000, 24'h0F0F0F, 1);

    // Write on the 2047->0 edge: current frame keeps the old pair.
    wait_cnt(11'd2047);
    lft_in = 24'h123456; rht_in = 24'h0ABCDE; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    frame_check("coll cur", 1'b0, '0, '0, 24'h800000, 24'h0F0F0F, 1);
    frame_check("coll next", 1'b0, '0, '0, 24'h123456, 24'h0ABCDE, 1);

    // Loop-back: feed a new sample on every frm_req, expect one frame delay.
    for (int k = 0; k < 4; k++)
      frame_check($sformatf("loop%0d", k), 1'b1, sine[k], ~sine[k],
                  (k == 0) ? 24'h123456 : sine[k-1],
                  (k == 0) ? 24'h0ABCDE : ~sine[k-1], 1);

    // Mid-frame reset at cnt 600 (slot 18, SCLK high, data bit = 1).
    write_at(11'd1000, 24'hFFFFFF, 24'hFFFFFF);
    wait_cnt(11'd0);
    wait_cnt(11'd600);
    chk("pre SCLK", SCLK, 1);
    chk("pre SDin", SDin, 1);
    rst_n = 1'b0;
    #1;
    chk("mid SDin", SDin, 0);
    chk("mid SCLK", SCLK, 0);
    chk("mid LRCLK", LRCLK, 0);
    chk("mid frm_req", frm_req, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (frm_req !== 1'b1 && n < 2100) begin
      @(negedge clk);
      n++;
    end
    chk("req after rst", n, 2048);
    frame_check("post rst", 1'b0, '0, '0, 24'h0, 24'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-002 SHALL have port RST_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port lft_in, input, 24, signed left sample to transmit.
REQ-004 SHALL have port rht_in, input, 24, signed right sample to transmit.
REQ-005 SHALL have port wrt, input, 1, one-clk strobe that captures lft_in and rht_in into the holding registers.
REQ-006 SHALL have port frm_req, output, 1, one-clk pulse when holding data moves to the shifters; upstream may write the next pair.
REQ-007 SHALL have port MCLK, output, 1, codec master clock, clk/4.
REQ-008 SHALL have port SCLK, output, 1, serial bit clock, clk/32.
REQ-009 SHALL have port LRCLK, output, 1, frame clock, clk/2048 (24414 Hz); low = left slot.
REQ-010 SHALL have port SDin, output, 1, serial data to codec.

Function
REQ-011 SHALL run an 11-bit free-running counter cnt, incrementing every clk and wrapping 2047->0.
REQ-012 SHALL drive MCLK=cnt[1], SCLK=cnt[4] and LRCLK=cnt[10] straight from flops, with no combinational decode.
REQ-013 SHALL provide 32 SCLK periods per LRCLK half; slot index b=cnt[9:5].
REQ-014 SHALL change SDin only at SCLK falling edges (cnt[4:0] wraps 31->0), so it is stable at every SCLK rising edge.
REQ-015 SHALL drive SDin=0 in slot b=0, data bit [24-b] in slots b=1..24 (MSB first, I2S one-bit delay), and 0 in slots b=25..31.
REQ-016 SHALL send the left shifter while LRCLK=0 and the right shifter while LRCLK=1.
REQ-017 SHALL keep separate holding registers (lft_hld, rht_hld) and shift registers (lft_shft, rht_shft), all 24 bits.
REQ-018 SHALL load both holding registers from lft_in/rht_in on the clk edge where wrt=1.
REQ-019 SHALL copy both holding registers into the shifters on the cnt 2047->0 edge and assert frm_req for exactly that one clk.
REQ-020 If wrt and the frame copy fall on the same edge: SHALL load the shifters with the old holding values, and the new wrt data SHALL go out in the next frame.
REQ-021 If no wrt occurs between frames: SHALL resend the previous holding values; there is no underflow indication.
REQ-022 If wrt occurs more than once between frames: the last write SHALL win.
REQ-023 Latency: a sample written before the frame edge SHALL reach SDin MSB 32 clks (one SCLK) after LRCLK falls.

Reset
REQ-024 While RST_n=0: cnt=0, MCLK=0, SCLK=0, LRCLK=0, SDin=0, frm_req=0, all holding and shift registers=0.
REQ-025 On RST_n release: counting SHALL start on the next clk; the first frame SHALL send zeros unless wrt arrives before cnt first wraps.
REQ-026 RST_n asserted mid-frame SHALL force all outputs to reset values immediately, with no partial-word completion.

Structure
REQ-027 Shared package eq_pkg SHALL hold SMPL_W=24, CNT_W=11, SLOTS=32 and MCLK_BIT/SCLK_BIT/LRCLK_BIT indices.
REQ-028 SHALL have one sub-module, i2s_clk_gen (counter plus clock outputs plus sclk_fall/frame_start strobes), instantiated by i2s_tx.
REQ-029 Shifting SHALL occur only on sclk_fall qualified by slot range; there is no extra FSM beyond the counter.

Verification
REQ-030 Scenario, clocks after reset release: MCLK period 80 ns, SCLK period 640 ns, LRCLK period 40.96 us, 50% duty each.
REQ-031 Scenario, single frame: wrt with lft_in=24'hA5A5A5, rht_in=24'h5A5A5A before the frame edge -> the bench, sampling SDin on SCLK rise, recovers both words MSB first in slots 1..24 with 0 elsewhere.
REQ-032 Scenario, collision: wrt with lft_in=24'h123456 on the cnt 2047->0 edge -> the current frame carries the prior value and the next frame carries 24'h123456; frm_req pulses once per frame.
REQ-033 Scenario, no writes: wrt with lft_in=24'h800000 (negative full scale), then no further writes for 3 frames -> 24'h800000 repeats every left slot; frm_req pulses every 2048 clks.
REQ-034 Scenario, mid-frame reset: RST_n low at cnt=600 -> SDin, SCLK and LRCLK all 0 within the same time step; after release the first frm_req comes 2048 clks later.
REQ-035 Scenario, loop-back: the CS4272 codec model on SDin with a 1 kHz sine fed via wrt on each frm_req -> codec aout_lft matches the input top 16 bits with one frame of delay.
